sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between ICache line refill (4-word burst) and data-side single-word load/store.
- Sits between the ICache miss path / LSU and the SRAM macro.
- Round-robin arbitration when both sides request together; one transaction in flight at a time.
- SRAM has 1-cycle read latency: address in cycle N, rdata in N+1.

Parameters:
- IC_BURST_LEN, 4, words per ICache line refill; line = IC_BURST_LEN*4 bytes = 16B.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ic_req_valid  in  1  ICache refill request
- ic_req_addr  in  32  refill address; bits [3:0] ignored (line-aligned)
- ic_req_ready  out  1  refill request accepted this cycle
- ic_rdata  out  32  refill beat data
- ic_rdata_valid  out  1  ic_rdata valid this cycle
- ic_rdata_last  out  1  marks final beat (beat index IC_BURST_LEN-1)
- dc_req_valid  in  1  data request
- dc_req_wr  in  1  1=store, 0=load
- dc_req_addr  in  32  word address; bits [1:0] ignored
- dc_req_wdata  in  32  store data
- dc_req_wstrb  in  4  store byte enables
- dc_req_ready  out  1  data request accepted this cycle
- dc_resp_valid  out  1  load data valid / store complete
- dc_rdata  out  32  load data; don't-care for stores
- sram_en  out  1  SRAM access enable
- sram_we  out  4  byte write enables; 0 = read
- sram_addr  out  32  SRAM byte address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, one cycle after sram_en

Behaviour:
- Handshake:
  - Request accepted when valid && ready.
  - Requester holds valid and payload stable until accepted.
  - Ready is asserted only in IDLE, and to at most one requester per cycle.
- State machine: IDLE, IC_BURST, DC_ACCESS.
- IDLE:
  - No SRAM access (sram_en=0).
  - Only ic_req_valid: assert ic_req_ready; latch addr[31:4]; clear beat_cnt; go IC_BURST.
  - Only dc_req_valid: assert dc_req_ready; latch addr, wr, wdata, wstrb; go DC_ACCESS.
  - Both valid: grant the side not granted last (last_grant reg). After reset, DC wins the first tie.
- IC_BURST:
  - Each cycle: sram_en=1, sram_we=0, sram_addr={line[31:4], beat_cnt[1:0], 2'b00}; beat_cnt increments.
  - After issuing beat IC_BURST_LEN-1, go IDLE; last_grant=IC.
- DC_ACCESS (one cycle):
  - sram_en=1, sram_addr={addr[31:2], 2'b00}, sram_we = wr ? wstrb : 4'b0000, sram_wdata=wdata.
  - Go IDLE; last_grant=DC.
- Response pipeline:
  - Registered owner/beat tags (resp_ic_q, resp_last_q, resp_dc_q) are set in the issue cycle.
  - Next cycle: ic_rdata_valid=resp_ic_q with ic_rdata=sram_rdata; ic_rdata_last=resp_last_q; dc_resp_valid=resp_dc_q with dc_rdata=sram_rdata.
  - Response of the last access overlaps the following IDLE cycle. Responses never overlap each other.
- Latency from acceptance at cycle T:
  - IC: addresses T+1..T+4, beats T+2..T+5, last at T+5.
  - DC: access T+1, response T+2.
  - A new request can be accepted at T+5 (IC) or T+2 (DC).
- Reset at any time, including mid-burst:
  - Next cycle state=IDLE, beat_cnt=0, last_grant=IC (DC wins first tie).
  - All tag regs cleared; in-flight beats are dropped with no valid pulse.
- Outputs during rst cycle: ic_req_ready=0, dc_req_ready=0, sram_en=0, sram_we=0, ic_rdata_valid=0, ic_rdata_last=0, dc_resp_valid=0.
- Idle outputs: sram_en=0, sram_we=0; sram_addr/sram_wdata don't-care.
- beat_cnt wraps after IC_BURST_LEN-1; no address carry outside the line.

Test Plan:
- IC only, ic_req_addr=0x1C00_0038 accepted at T -> sram_addr 0x1C000030,34,38,3C at T+1..T+4; ic_rdata_valid T+2..T+5; last only at T+5; dc_req_ready=0 throughout.
- DC load 0x0000_1006 at T -> T+1 sram_en=1, sram_we=0, sram_addr=0x00001004; T+2 dc_resp_valid=1, dc_rdata=SRAM word.
- DC store addr 0x80, wdata 0xDEADBEEF, wstrb 4'b0011 -> T+1 sram_we=4'b0011, sram_wdata=0xDEADBEEF; T+2 dc_resp_valid=1.
- Both valid continuously after reset -> grants DC, IC, DC, IC alternate; never both ready in the same cycle.
- rst asserted at the cycle of beat 2 issue -> next cycle IDLE, no further ic_rdata_valid, sram_en=0; a fresh IC request then completes all 4 beats.
- Back-to-back: IC burst then queued DC -> dc_req_ready at T+5, coincident with ic_rdata_last; DC access at T+6.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one synchronous single-port SRAM (1-cycle read latency) between
//   ICache line refill (IC_BURST_LEN-word burst) and data-side single-word
//   load/store. One transaction in flight at a time; round-robin on ties.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   ic_req_valid/addr/ready          refill request (addr line-aligned, low bits ignored)
//   ic_rdata/_valid/_last            refill beat data, valid, final-beat marker
//   dc_req_valid/wr/addr/wdata/wstrb data request (addr word-aligned, low bits ignored)
//   dc_req_ready                     data request accepted this cycle
//   dc_resp_valid, dc_rdata          load data / store completion
//   sram_en/we/addr/wdata            SRAM command (we = 0 means read)
//   sram_rdata                       SRAM read data, one cycle after sram_en
module sram_port_arbiter #(
  parameter int IC_BURST_LEN = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic [31:0]       ic_rdata,
  output logic              ic_rdata_valid,
  output logic              ic_rdata_last,
  input  logic              dc_req_valid,
  input  logic              dc_req_wr,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [31:0]       dc_req_wdata,
  input  logic [3:0]        dc_req_wstrb,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [31:0]       dc_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int DATA_W   = 32;
  localparam int BEAT_W   = (IC_BURST_LEN > 1) ? $clog2(IC_BURST_LEN) : 1;
  localparam int LINE_LSB = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IC_BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IC_BURST  = 2'd1,
    DC_ACCESS = 2'd2
  } state_t;

  state_t                     state;
  logic [BEAT_W-1:0]          beat_cnt;
  logic                       last_grant_dc;   // 1: data side won the last transaction
  logic                       resp_ic_q;
  logic                       resp_last_q;
  logic                       resp_dc_q;

  // Request payload holding registers (data path, no reset needed)
  logic [ADDR_W-LINE_LSB-1:0] ic_line;
  logic [ADDR_W-3:0]          dc_word;
  logic                       dc_wr;
  logic [DATA_W-1:0]          dc_wdata;
  logic [3:0]                 dc_wstrb;

  logic                       grant_ic;
  logic                       grant_dc;

  // Sub-line / sub-word address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_req_addr[LINE_LSB-1:0], dc_req_addr[1:0]};

  // Arbitration: only in IDLE and never during reset; a tie goes to the side
  // that did not win last time.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (!rst && state == IDLE) begin
      if (ic_req_valid && dc_req_valid) begin
        grant_ic = last_grant_dc;
        grant_dc = !last_grant_dc;
      end else begin
        grant_ic = ic_req_valid;
        grant_dc = dc_req_valid;
      end
    end
  end

  assign ic_req_ready = grant_ic;
  assign dc_req_ready = grant_dc;

  // Control FSM and response tags
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      last_grant_dc <= 1'b0;
      resp_ic_q     <= 1'b0;
      resp_last_q   <= 1'b0;
      resp_dc_q     <= 1'b0;
    end else begin
      resp_ic_q   <= (state == IC_BURST);
      resp_last_q <= (state == IC_BURST) && (beat_cnt == LAST_BEAT);
      resp_dc_q   <= (state == DC_ACCESS);
      case (state)
        IDLE: begin
          if (grant_ic) begin
            state    <= IC_BURST;
            beat_cnt <= '0;
          end else if (grant_dc) begin
            state    <= DC_ACCESS;
          end
        end
        IC_BURST: begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state         <= IDLE;
            last_grant_dc <= 1'b0;
          end
        end
        DC_ACCESS: begin
          state         <= IDLE;
          last_grant_dc <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk) begin
    if (grant_ic) begin
      ic_line <= ic_req_addr[ADDR_W-1:LINE_LSB];
    end
    if (grant_dc) begin
      dc_word  <= dc_req_addr[ADDR_W-1:2];
      dc_wr    <= dc_req_wr;
      dc_wdata <= dc_req_wdata;
      dc_wstrb <= dc_req_wstrb;
    end
  end

  // SRAM command: decoded from registered state; reset suppresses any access
  // in the same cycle so an in-flight store cannot land during reset.
  assign sram_en    = !rst && (state != IDLE);
  assign sram_we    = (!rst && state == DC_ACCESS && dc_wr) ? dc_wstrb : 4'b0000;
  assign sram_addr  = (state == DC_ACCESS) ? {dc_word, 2'b00} : {ic_line, beat_cnt, 2'b00};
  assign sram_wdata = dc_wdata;

  // Response stage: tags from the issue cycle qualify the SRAM read data
  assign ic_rdata       = sram_rdata;
  assign dc_rdata       = sram_rdata;
  assign ic_rdata_valid = resp_ic_q && !rst;
  assign ic_rdata_last  = resp_last_q && !rst;
  assign dc_resp_valid  = resp_dc_q && !rst;

endmodule
